// File: rtl/cardinal_nic_pkg.sv
// Shared register map and bit positions for the Cardinal NIC.
// Bit numbering is big-endian: bit 0 is the MSB, bit 63 is the LSB.
package cardinal_nic_pkg;

    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    // Status flag sits in the LSB of the status word.
    localparam int NIC_STATUS_BIT = 63;
    // Virtual-channel / polarity bit is the MSB of a packet.
    localparam int NIC_VC_BIT     = 0;

endpackage

// File: rtl/nic_fifo.sv
// Single-clock FIFO used for both NIC channels. A push coincident with a
// pop is accepted even when full, because the pop frees the slot on the
// same edge.
module nic_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [0:DATA_WIDTH-1] din,
    output logic [0:DATA_WIDTH-1] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Storage sized to the pointer range so indexing is always full width.
    localparam int MEM_N = 1 << PTR_W;

    logic [0:DATA_WIDTH-1] mem_q [MEM_N];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count registers; reset discards contents at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC top: CPU register decode, read mux and ring injection
// gating on router polarity. All storage lives in the two nic_fifo copies.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  cpu_rd, cpu_wr;
    logic                  in_push, in_pop, in_full, in_empty;
    logic                  out_push, out_full, out_empty;
    logic [0:DATA_WIDTH-1] in_head, out_head;

    assign cpu_rd = nicEn & ~nicWrEn;
    assign cpu_wr = nicEn &  nicWrEn;

    assign in_pop   = cpu_rd & (addr == NIC_ADDR_IN_BUF);
    assign net_ri   = ~in_full;
    // A router packet is also taken when the CPU frees the slot this edge.
    assign in_push  = net_si & (net_ri | (in_pop & ~in_empty));
    // Full-FIFO writes are dropped inside nic_fifo unless a pop coincides.
    assign out_push = cpu_wr & (addr == NIC_ADDR_OUT_BUF);

    assign net_so = ~out_empty & net_ro & (out_head[NIC_VC_BIT] == net_polarity);
    assign net_do = out_head;

    nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (net_di),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (net_so),
        .din   (d_in),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    // CPU read mux; zero whenever no read is in progress.
    always_comb begin
        d_out = '0;
        if (cpu_rd) begin
            case (addr)
                NIC_ADDR_IN_BUF:   d_out = in_head;
                NIC_ADDR_IN_STAT:  d_out[NIC_STATUS_BIT] = in_full;
                NIC_ADDR_OUT_STAT: d_out[NIC_STATUS_BIT] = out_full;
                default:           d_out = '0;
            endcase
        end
    end

endmodule
